// File: rtl/rv_mem_pkg.sv
// Shared types and width helpers for the unified-memory port arbiter.
package rv_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  function automatic int unsigned lat_cnt_w(input int unsigned mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

  function automatic int unsigned starve_w(input int unsigned starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the IF/DM memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Core datapath plus memory: drives requests and read data.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  // The arbiter itself.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/arb_prio_sel.sv
// Fixed-priority winner select (DM over IF) with IF starvation guard.
module arb_prio_sel #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned SW         = rv_mem_pkg::starve_w(STARVE_MAX)
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [SW-1:0] starve,
  output logic          if_win_c,
  output logic          dm_win_c,
  output logic [SW-1:0] starve_nxt_c
);

  // A DM win with IF waiting implies starve < STARVE_MAX, so the increment saturates by construction.
  always_comb begin
    dm_win_c     = dm_req && (!if_req || (starve < SW'(STARVE_MAX)));
    if_win_c     = if_req && !dm_win_c;
    starve_nxt_c = starve;
    if (dm_win_c) begin
      starve_nxt_c = if_req ? (starve + SW'(1)) : '0;
    end else if (if_win_c) begin
      starve_nxt_c = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and DM; one access in flight,
// sequenced IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LAT_W = lat_cnt_w(MEM_LAT);
  localparam int unsigned SW    = starve_w(STARVE_MAX);

  arb_state_e        state;
  owner_e            owner;
  logic              wr_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SW-1:0]     starve;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              busy_q;

  logic              if_win_c;
  logic              dm_win_c;
  logic [SW-1:0]     starve_nxt_c;
  logic              arb_open_c;

  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .if_req       (bus.if_req),
    .dm_req       (bus.dm_req),
    .starve       (starve),
    .if_win_c     (if_win_c),
    .dm_win_c     (dm_win_c),
    .starve_nxt_c (starve_nxt_c)
  );

  // Grants are combinational and only offered from IDLE outside reset.
  assign arb_open_c = (state == IDLE) && !reset;
  assign bus.if_gnt = arb_open_c && if_win_c;
  assign bus.dm_gnt = arb_open_c && dm_win_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      wr_q        <= 1'b0;
      lat_cnt     <= '0;
      starve      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_win_c || if_win_c) begin
            state       <= ISSUE;
            busy_q      <= 1'b1;
            owner       <= dm_win_c ? OWN_DM : OWN_IF;
            wr_q        <= dm_win_c && bus.dm_we;
            starve      <= starve_nxt_c;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_win_c && bus.dm_we;
            mem_be_q    <= (dm_win_c && bus.dm_we) ? bus.dm_be : '1;
            mem_addr_q  <= dm_win_c ? bus.dm_addr : bus.if_addr;
            mem_wdata_q <= (dm_win_c && bus.dm_we) ? bus.dm_wdata : '0;
          end
        end
        ISSUE: begin
          state       <= WAIT;
          lat_cnt     <= '0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_be_q    <= '0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          // Last WAIT edge: memory data is valid now.
          if (lat_cnt == LAT_W'(MEM_LAT - 1)) begin
            state <= RESP;
            if (owner == OWN_DM) begin
              dm_rvalid_q <= 1'b1;
              dm_rdata_q  <= wr_q ? '0 : bus.mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: one arbiter at MEM_LAT=1 and one at MEM_LAT=3, each with a behavioural memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        dm;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [31:0] ref1 [0:4095];
  logic [31:0] ref3 [0:4095];
  logic [31:0] rd1;
  logic [31:0] p3 [0:2];
  int unsigned cyc = 0;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Behavioural memories: read data appears MEM_LAT cycles after mem_en; junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd1 <= 32'hBAD0_0000 | cyc;
    if (b1.mem_en) begin
      if (b1.mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b1.mem_be[k]) mem1[b1.mem_addr][8*k +: 8] = b1.mem_wdata[8*k +: 8];
      end else rd1 <= mem1[b1.mem_addr];
    end
    p3[0] <= 32'hBAD3_0000 | cyc;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (b3.mem_en) begin
      if (b3.mem_we) begin
        for (int k = 0; k < 4; k++)
          if (b3.mem_be[k]) mem3[b3.mem_addr][8*k +: 8] = b3.mem_wdata[8*k +: 8];
      end else p3[0] <= mem3[b3.mem_addr];
    end
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = p3[2];

  // Response monitors pop the scoreboard on every rvalid.
  always @(negedge clk) begin
    if (!reset && (b1.if_rvalid || b1.dm_rvalid)) begin
      if (q1.size() == 0) chk("sb1_unexpected_rvalid", 32'(b1.dm_rvalid), 32'(1'b0));
      else begin
        e1 = q1.pop_front();
        chk("sb1_both_rvalid", 32'(b1.if_rvalid & b1.dm_rvalid), 0);
        chk("sb1_port", 32'(b1.dm_rvalid), 32'(e1.dm));
        chk("sb1_data", e1.dm ? b1.dm_rdata : b1.if_rdata, e1.data);
      end
    end
    if (!reset && (b3.if_rvalid || b3.dm_rvalid)) begin
      if (q3.size() == 0) chk("sb3_unexpected_rvalid", 32'(b3.dm_rvalid), 32'(1'b0));
      else begin
        e3 = q3.pop_front();
        chk("sb3_both_rvalid", 32'(b3.if_rvalid & b3.dm_rvalid), 0);
        chk("sb3_port", 32'(b3.dm_rvalid), 32'(e3.dm));
        chk("sb3_data", e3.dm ? b3.dm_rdata : b3.if_rdata, e3.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  // Drive one DM transaction on the MEM_LAT=3 port and let it run to IDLE.
  task automatic dm3(input logic we, input logic [11:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata);
    exp_t e;
    b3.dm_req = 1'b1; b3.dm_we = we; b3.dm_addr = addr; b3.dm_be = be; b3.dm_wdata = wdata;
    e.dm = 1'b1;
    if (we) begin
      for (int k = 0; k < 4; k++) if (be[k]) ref3[addr][8*k +: 8] = wdata[8*k +: 8];
      e.data = '0;
    end else e.data = ref3[addr];
    q3.push_back(e);
    #1 chk("dm3_gnt", 32'(b3.dm_gnt), 1);
    @(negedge clk);
    b3.dm_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int   ngnt;
  int   nboth;
  exp_t e;

  initial begin
    b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0;
    b1.dm_be = '0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0;
    b3.dm_be = '0; b3.dm_addr = '0; b3.dm_wdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = init_word(i); ref1[i] = init_word(i);
      mem3[i] = init_word(i); ref3[i] = init_word(i);
    end
    mem1[16] = 32'h0050_0093; ref1[16] = 32'h0050_0093;

    // Reset held for three cycles: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_b1_ctl", 32'({b1.if_gnt, b1.dm_gnt, b1.if_rvalid, b1.dm_rvalid,
                            b1.mem_en, b1.mem_we, b1.busy}), 0);
    chk("rst_b1_data", b1.if_rdata | b1.dm_rdata | b1.mem_wdata, 0);
    chk("rst_b1_addr", 32'({b1.mem_be, b1.mem_addr}), 0);
    chk("rst_b3_ctl", 32'({b3.if_rvalid, b3.dm_rvalid, b3.mem_en, b3.busy}), 0);
    reset = 1'b0;
    @(negedge clk);

    // IF read at MEM_LAT=1.
    b1.if_req = 1'b1; b1.if_addr = 12'h010;
    e.dm = 1'b0; e.data = 32'h0050_0093; q1.push_back(e);
    #1 chk("t2_if_gnt", 32'(b1.if_gnt), 1);
    chk("t2_dm_gnt", 32'(b1.dm_gnt), 0);
    @(negedge clk);
    b1.if_req = 1'b0;
    chk("t2_mem_en", 32'(b1.mem_en), 1);
    chk("t2_mem_addr", 32'(b1.mem_addr), 32'h010);
    chk("t2_mem_we", 32'(b1.mem_we), 0);
    chk("t2_mem_be", 32'(b1.mem_be), 32'hF);
    chk("t2_busy", 32'(b1.busy), 1);
    @(negedge clk);
    chk("t2_mem_en_wait", 32'(b1.mem_en), 0);
    chk("t2_rvalid_early", 32'(b1.if_rvalid), 0);
    @(negedge clk);
    chk("t2_rvalid", 32'(b1.if_rvalid), 1);
    @(negedge clk);
    chk("t2_rvalid_pulse", 32'(b1.if_rvalid), 0);
    chk("t2_rdata_hold", b1.if_rdata, 32'h0050_0093);
    chk("t2_idle", 32'(b1.busy), 0);

    // Asynchronous reset during ISSUE clears outputs without a clock edge.
    b1.if_req = 1'b1; b1.if_addr = 12'h011;
    @(negedge clk);
    b1.if_req = 1'b0;
    chk("t1_pre_mem_en", 32'(b1.mem_en), 1);
    #2 reset = 1'b1;
    #1 chk("t1_async_busy", 32'(b1.busy), 0);
    chk("t1_async_mem_en", 32'(b1.mem_en), 0);
    chk("t1_async_rdata", b1.if_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Collision: DM store wins, IF granted at the next IDLE.
    b1.if_req = 1'b1; b1.if_addr = 12'h030;
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 12'h020;
    b1.dm_wdata = 32'hDEAD_BEEF; b1.dm_be = 4'hF;
    ref1[12'h020] = 32'hDEAD_BEEF;
    e.dm = 1'b1; e.data = '0; q1.push_back(e);
    e.dm = 1'b0; e.data = ref1[12'h030]; q1.push_back(e);
    #1 chk("t3_dm_gnt", 32'(b1.dm_gnt), 1);
    chk("t3_if_gnt_blocked", 32'(b1.if_gnt), 0);
    @(negedge clk);
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    chk("t3_mem_we", 32'(b1.mem_we), 1);
    chk("t3_mem_addr", 32'(b1.mem_addr), 32'h020);
    chk("t3_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_be", 32'(b1.mem_be), 32'hF);
    for (int c = 1; c < 4; c++) begin
      #1 chk("t3_no_if_gnt", 32'(b1.if_gnt), 0);
      @(negedge clk);
    end
    #1 chk("t3_if_gnt_t4", 32'(b1.if_gnt), 1);
    @(negedge clk);
    b1.if_req = 1'b0;
    chk("t3_if_mem_addr", 32'(b1.mem_addr), 32'h030);
    chk("t3_if_mem_we", 32'(b1.mem_we), 0);
    repeat (3) @(negedge clk);
    chk("t3_store_in_mem", mem1[12'h020], 32'hDEAD_BEEF);

    // Starvation guard: four DM grants, one IF grant, repeated.
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 12'h040;
    b1.if_req = 1'b1; b1.if_addr = 12'h050;
    for (int k = 0; k < 10; k++) begin
      e.dm = ((k % 5) != 4);
      e.data = e.dm ? ref1[12'h040] : ref1[12'h050];
      q1.push_back(e);
    end
    ngnt = 0; nboth = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (b1.if_gnt && b1.dm_gnt) nboth++;
      if (b1.if_gnt || b1.dm_gnt) begin
        chk("t4_gnt_is_dm", 32'(b1.dm_gnt), 32'((ngnt % 5) != 4));
        ngnt++;
      end
      @(negedge clk);
    end
    b1.dm_req = 1'b0; b1.if_req = 1'b0;
    chk("t4_grant_count", 32'(ngnt), 10);
    chk("t4_both_gnt_cycles", 32'(nboth), 0);
    @(negedge clk);

    // Reset during WAIT at MEM_LAT=3 abandons the access.
    b3.if_req = 1'b1; b3.if_addr = 12'h123;
    @(negedge clk);
    b3.if_req = 1'b0;
    chk("t5_mem_en", 32'(b3.mem_en), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("t5_async_busy", 32'(b3.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    b3.if_req = 1'b1; b3.if_addr = 12'h123;
    e.dm = 1'b0; e.data = ref3[12'h123]; q3.push_back(e);
    #1 chk("t5_if_gnt", 32'(b3.if_gnt), 1);
    @(negedge clk);
    b3.if_req = 1'b0;
    repeat (6) @(negedge clk);

    // DM load at the top address, MEM_LAT=3: rvalid five cycles after grant.
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 12'hFFF; b3.dm_be = 4'h0;
    e.dm = 1'b1; e.data = ref3[12'hFFF]; q3.push_back(e);
    #1 chk("t6_dm_gnt", 32'(b3.dm_gnt), 1);
    @(negedge clk);
    b3.dm_req = 1'b0;
    chk("t6_mem_en", 32'(b3.mem_en), 1);
    chk("t6_mem_addr", 32'(b3.mem_addr), 32'hFFF);
    chk("t6_mem_be", 32'(b3.mem_be), 32'hF);
    repeat (3) @(negedge clk);
    chk("t6_rvalid_early", 32'(b3.dm_rvalid), 0);
    @(negedge clk);
    chk("t6_rvalid_t5", 32'(b3.dm_rvalid), 1);
    @(negedge clk);

    // Partial store then load at the same address.
    dm3(1'b1, 12'h0AB, 4'b0101, 32'h1122_3344);
    dm3(1'b0, 12'h0AB, 4'h0, 32'h0);
    dm3(1'b1, 12'hFFF, 4'hF, 32'hCAFE_F00D);
    dm3(1'b0, 12'hFFF, 4'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
